// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) in front of a single-port RAM with 1-cycle responses.
// Define MEM_ARB_STATS_EN to add the conflict_cnt and i_stall_cnt statistics ports.
module mem_arbiter #(
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] conflict_cnt,
    output logic [31:0] i_stall_cnt
`endif
);

    typedef enum logic {OwnerI, OwnerD} owner_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    owner_e      last_owner_q, last_owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        i_rvalid_q, d_rvalid_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (ARB_MODE == 0) begin
                    if (starve_q == StarveMax) i_gnt = 1'b1;
                    else                       d_gnt = 1'b1;
                end else begin
                    if (last_owner_q == OwnerI) d_gnt = 1'b1;
                    else                        i_gnt = 1'b1;
                end
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    // RAM port defaults to the fetch address so an idle port still presents i_addr.
    always_comb begin
        ram_addr  = i_addr;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_wdata = 32'h0;
        if (d_gnt) begin
            ram_addr  = d_addr;
            ram_we    = d_we;
            ram_be    = d_be;
            ram_wdata = d_wdata;
        end
    end

    always_comb begin
        starve_d     = 4'd0;
        last_owner_d = last_owner_q;
        if (i_req && !i_gnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
        end
        if (i_gnt)      last_owner_d = OwnerI;
        else if (d_gnt) last_owner_d = OwnerD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q     <= 4'd0;
            last_owner_q <= OwnerI;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            starve_q     <= starve_d;
            last_owner_q <= last_owner_d;
            i_rvalid_q   <= i_gnt;
            d_rvalid_q   <= d_gnt;
            if (i_gnt)          i_rdata_q <= ram_rdata;
            if (d_gnt && !d_we) d_rdata_q <= ram_rdata;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_q, i_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 32'h0;
            i_stall_q  <= 32'h0;
        end else begin
            if (i_req && d_req && conflict_q != 32'hFFFF_FFFF) conflict_q <= conflict_q + 32'd1;
            if (i_req && !i_gnt && i_stall_q != 32'hFFFF_FFFF) i_stall_q <= i_stall_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign i_stall_cnt  = i_stall_q;
`endif

endmodule
